// File: rtl/psram16_pkg.sv
// rtl/psram16_pkg.sv - shared state encoding and default timing for the async PSRAM controller
package psram16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    localparam int DEF_ADDR_BITS    = 21;
    localparam int DEF_READ_CYCLES  = 4;
    localparam int DEF_WRITE_CYCLES = 4;
    localparam int CNT_W            = 8;
    localparam int RAM_A_W          = 22;

endpackage

// File: rtl/psram16_pads.sv
// rtl/psram16_pads.sv - registered PSRAM pin drivers, ram_d tristate and read-data sample register
import psram16_pkg::*;

module psram16_pads (
    input  logic               clock,
    input  logic               rst,
    input  logic               ce_n_d,
    input  logic               oe_n_d,
    input  logic               we_n_d,
    input  logic               lb_n_d,
    input  logic               ub_n_d,
    input  logic               a_load,
    input  logic [RAM_A_W-1:0] a_d,
    input  logic               d_oe_d,
    input  logic [15:0]        d_out_d,
    input  logic               sample_en,
    output logic [15:0]        rd_sample,
    output logic [RAM_A_W-1:0] ram_a,
    output logic               ram_ce_n,
    output logic               ram_oe_n,
    output logic               ram_we_n,
    output logic               ram_lb_n,
    output logic               ram_ub_n,
    inout  wire  [15:0]        ram_d
);

    logic        d_oe_q;
    logic [15:0] d_out_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_lb_n  <= 1'b1;
            ram_ub_n  <= 1'b1;
            ram_a     <= '0;
            d_oe_q    <= 1'b0;
            d_out_q   <= 16'h0000;
            rd_sample <= 16'h0000;
        end else begin
            ram_ce_n <= ce_n_d;
            ram_oe_n <= oe_n_d;
            ram_we_n <= we_n_d;
            ram_lb_n <= lb_n_d;
            ram_ub_n <= ub_n_d;
            d_oe_q   <= d_oe_d;
            d_out_q  <= d_out_d;
            // Address only moves while a phase is active so it holds through GAP.
            if (a_load) begin
                ram_a <= a_d;
            end
            if (sample_en) begin
                rd_sample <= ram_d;
            end
        end
    end

    assign ram_d = d_oe_q ? d_out_q : 16'bz;

endmodule

// File: rtl/psram16_async_ctrl.sv
// rtl/psram16_async_ctrl.sv - 32-bit mem_* bus to 16-bit async PSRAM bridge; PSRAM_WRITE_SKIP_EN skips empty write halves
import psram16_pkg::*;

module psram16_async_ctrl #(
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int READ_CYCLES  = DEF_READ_CYCLES,
    parameter int WRITE_CYCLES = DEF_WRITE_CYCLES
) (
    input  logic               clock,
    input  logic               rst,
    output logic               mem_waitrequest,
    input  logic [1:0]         mem_id,
    input  logic [29:0]        mem_address,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        mem_writedata,
    input  logic [3:0]         mem_writedatamask,
    output logic [31:0]        mem_readdata,
    output logic [1:0]         mem_readdataid,
    output logic [RAM_A_W-1:0] ram_a,
    inout  wire  [15:0]        ram_d,
    output logic               ram_ce_n,
    output logic               ram_oe_n,
    output logic               ram_we_n,
    output logic               ram_lb_n,
    output logic               ram_ub_n
);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_CYCLES - 1);

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, cur_addr;
    logic [1:0]             id_q;
    logic [31:0]            wdata_q, cur_data;
    logic [3:0]             mask_q, cur_mask;
    logic                   rd_op_q;
    logic [15:0]            rd_lo, rd_sample;
    logic                   accept;

    logic                   rd_ph, wr_ph, hi;
    logic [1:0]             half_mask;
    logic                   pin_ce_n, pin_oe_n, pin_we_n, pin_lb_n, pin_ub_n;
    logic [RAM_A_W-1:0]     pin_a;
    logic [15:0]            pin_d;
    logic                   sample_en;
    logic                   unused_addr_hi;

    assign unused_addr_hi  = ^mem_address[29:ADDR_BITS];
    assign mem_waitrequest = rst | (state != ST_IDLE);
    assign accept          = (state == ST_IDLE) & (mem_read | mem_write);

    // Pins are registered from next-state values, so the captured request is bypassed on accept.
    assign cur_addr = accept ? mem_address[ADDR_BITS-1:0] : addr_q;
    assign cur_data = accept ? mem_writedata : wdata_q;
    assign cur_mask = accept ? mem_writedatamask : mask_q;

    always_comb begin
        state_d = state;
        cnt_d   = (cnt != '0) ? cnt - 1'b1 : cnt;
        case (state)
            ST_IDLE: begin
                if (mem_write) begin
`ifdef PSRAM_WRITE_SKIP_EN
                    if (|mem_writedatamask[1:0]) begin
                        state_d = ST_WR_LO;
                        cnt_d   = WR_LOAD;
                    end else if (|mem_writedatamask[3:2]) begin
                        state_d = ST_WR_HI;
                        cnt_d   = WR_LOAD;
                    end else begin
                        state_d = ST_GAP;
                    end
`else
                    state_d = ST_WR_LO;
                    cnt_d   = WR_LOAD;
`endif
                end else if (mem_read) begin
                    state_d = ST_RD_LO;
                    cnt_d   = RD_LOAD;
                end
            end
            ST_RD_LO: begin
                if (cnt == '0) begin
                    state_d = ST_RD_HI;
                    cnt_d   = RD_LOAD;
                end
            end
            ST_RD_HI: begin
                if (cnt == '0) begin
                    state_d = ST_GAP;
                end
            end
            ST_WR_LO: begin
                if (cnt == '0) begin
`ifdef PSRAM_WRITE_SKIP_EN
                    if (|mask_q[3:2]) begin
                        state_d = ST_WR_HI;
                        cnt_d   = WR_LOAD;
                    end else begin
                        state_d = ST_GAP;
                    end
`else
                    state_d = ST_WR_HI;
                    cnt_d   = WR_LOAD;
`endif
                end
            end
            ST_WR_HI: begin
                if (cnt == '0) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_ph     = (state_d == ST_RD_LO) | (state_d == ST_RD_HI);
        wr_ph     = (state_d == ST_WR_LO) | (state_d == ST_WR_HI);
        hi        = (state_d == ST_RD_HI) | (state_d == ST_WR_HI);
        half_mask = hi ? cur_mask[3:2] : cur_mask[1:0];
        pin_ce_n  = ~(rd_ph | wr_ph);
        pin_oe_n  = ~rd_ph;
        // WE_N rises on the final clock of a write phase to give data/address hold.
        pin_we_n  = ~(wr_ph & (cnt_d != '0));
        pin_lb_n  = 1'b1;
        pin_ub_n  = 1'b1;
        if (rd_ph) begin
            pin_lb_n = 1'b0;
            pin_ub_n = 1'b0;
        end else if (wr_ph) begin
            pin_lb_n = ~half_mask[0];
            pin_ub_n = ~half_mask[1];
        end
        pin_a                = '0;
        pin_a[ADDR_BITS:0]   = {cur_addr, hi};
        pin_d                = hi ? cur_data[31:16] : cur_data[15:0];
        sample_en            = ((state == ST_RD_LO) | (state == ST_RD_HI)) & (cnt == '0);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            addr_q         <= '0;
            id_q           <= 2'b00;
            wdata_q        <= 32'h0;
            mask_q         <= 4'h0;
            rd_op_q        <= 1'b0;
            rd_lo          <= 16'h0;
            mem_readdata   <= 32'h0;
            mem_readdataid <= 2'b00;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            mem_readdataid <= 2'b00;
            if (accept) begin
                addr_q  <= mem_address[ADDR_BITS-1:0];
                id_q    <= mem_id;
                wdata_q <= mem_writedata;
                mask_q  <= mem_writedatamask;
                rd_op_q <= mem_read & ~mem_write;
            end
            // Low half is rescued on the first RD_HI clock, before the high sample overwrites it.
            if ((state == ST_RD_HI) && (cnt == RD_LOAD)) begin
                rd_lo <= rd_sample;
            end
            if ((state == ST_GAP) && rd_op_q) begin
                mem_readdata   <= {rd_sample, rd_lo};
                mem_readdataid <= id_q;
            end
        end
    end

    psram16_pads u_pads (
        .clock     (clock),
        .rst       (rst),
        .ce_n_d    (pin_ce_n),
        .oe_n_d    (pin_oe_n),
        .we_n_d    (pin_we_n),
        .lb_n_d    (pin_lb_n),
        .ub_n_d    (pin_ub_n),
        .a_load    (rd_ph | wr_ph),
        .a_d       (pin_a),
        .d_oe_d    (wr_ph),
        .d_out_d   (pin_d),
        .sample_en (sample_en),
        .rd_sample (rd_sample),
        .ram_a     (ram_a),
        .ram_ce_n  (ram_ce_n),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n),
        .ram_lb_n  (ram_lb_n),
        .ram_ub_n  (ram_ub_n),
        .ram_d     (ram_d)
    );

endmodule

// File: tb/tb_psram16_async_ctrl.sv
// tb/tb_psram16_async_ctrl.sv - directed and random checks of psram16_async_ctrl against a word-level memory model
module tb_psram16_async_ctrl;
    import psram16_pkg::*;

    localparam int RC = 4;
    localparam int WC = 4;
`ifdef PSRAM_WRITE_SKIP_EN
    localparam int MASK4_CE = WC;
`else
    localparam int MASK4_CE = 2 * WC;
`endif

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        mem_waitrequest;
    logic [1:0]  mem_id = 2'b00;
    logic [29:0] mem_address = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_writedata = '0;
    logic [3:0]  mem_writedatamask = '0;
    logic [31:0] mem_readdata;
    logic [1:0]  mem_readdataid;
    logic [21:0] ram_a;
    tri1  [15:0] ram_d;
    logic        ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;

    psram16_async_ctrl dut (
        .clock(clock), .rst(rst), .mem_waitrequest(mem_waitrequest), .mem_id(mem_id),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_writedatamask(mem_writedatamask),
        .mem_readdata(mem_readdata), .mem_readdataid(mem_readdataid), .ram_a(ram_a),
        .ram_d(ram_d), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        int          at;
    } ret_t;
    ret_t        rq[$];
    logic [31:0] emem[int];
    logic [15:0] pmem[int];
    int          last_acc;
    int          last_ce_run = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [29:0] a);
        int k = int'(a & 30'h1FFFFF);
        return emem.exists(k) ? emem[k] : 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // PSRAM device model: data appears only after the address has been stable for a while.
    logic        model_oe;
    logic [15:0] model_d = 16'h0;
    assign model_oe = ~ram_ce_n & ~ram_oe_n & ram_we_n;
    assign ram_d = model_oe ? model_d : 16'hzzzz;

    int          stab = 0, we_run = 0, ce_run = 0;
    logic        prev_we = 1'b1;
    logic [21:0] last_a = '0;
    always @(negedge clock) begin
        if (rst) begin
            stab = 0; we_run = 0; ce_run = 0; prev_we = 1'b1;
        end else begin
            if (!ram_we_n) we_run++;
            if (!prev_we && ram_we_n) begin
                chk("twp", we_run, WC - 1);
                we_run = 0;
                if (!ram_ce_n) begin
                    logic [15:0] w;
                    w = pmem.exists(int'(ram_a)) ? pmem[int'(ram_a)] : 16'h0;
                    if (!ram_lb_n) w[7:0] = ram_d[7:0];
                    if (!ram_ub_n) w[15:8] = ram_d[15:8];
                    pmem[int'(ram_a)] = w;
                end
            end
            prev_we = ram_we_n;
            if (!ram_ce_n) ce_run++;
            else if (ce_run != 0) begin
                chk("ce_max", (ce_run <= 2 * ((RC > WC) ? RC : WC)) ? 1 : 0, 1);
                last_ce_run = ce_run;
                ce_run = 0;
            end
            if (ram_ce_n || ram_oe_n) stab = 0;
            else if (ram_a != last_a) stab = 1;
            else stab++;
            last_a = ram_a;
            model_d = (stab >= 2) ? (pmem.exists(int'(ram_a)) ? pmem[int'(ram_a)] : 16'h0) : 16'hBAD0;
        end
    end

    always @(negedge clock) begin
        ret_t e;
        if (!rst && mem_readdataid != 2'b00) begin
            if (rq.size() == 0) chk("stray_return", mem_readdataid, 0);
            else begin
                e = rq.pop_front();
                chk("ret_id", mem_readdataid, e.id);
                chk("ret_data", mem_readdata, e.data);
                chk("ret_cycle", cyc, e.at);
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [29:0] a, input logic [1:0] id,
                         input logic [31:0] d, input logic [3:0] m, input bit hold, input bit push);
        int   n = 0;
        ret_t e;
        mem_read = rd; mem_write = wr; mem_address = a; mem_id = id;
        mem_writedata = d; mem_writedatamask = m;
        while (mem_waitrequest !== 1'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("accept_wait", (n < 100) ? 1 : 0, 1);
        @(posedge clock);
        #1;
        last_acc = cyc;
        if (wr) emem[int'(a & 30'h1FFFFF)] = merge(exp_rd(a), d, m);
        else if (rd && push) begin
            e.id = id; e.data = exp_rd(a); e.at = cyc + 2 * RC + 1;
            rq.push_back(e);
        end
        if (!hold) begin
            mem_read = 1'b0; mem_write = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || mem_waitrequest) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("drain", rq.size(), 0);
    endtask

    initial begin
        int            a1, a2, a3;
        logic [20:0]   pool[8];
        pool = '{21'h0, 21'h1, 21'h3, 21'h10, 21'h20, 21'h1FFFFF, 21'h0ABCDE, 21'h100000};

        repeat (3) @(negedge clock);
        chk("rst_wait", mem_waitrequest, 1);
        chk("rst_ce", ram_ce_n, 1);
        chk("rst_oe", ram_oe_n, 1);
        chk("rst_we", ram_we_n, 1);
        chk("rst_lbub", {ram_lb_n, ram_ub_n}, 2'b11);
        chk("rst_d_hiz", ram_d, 16'hFFFF);
        chk("rst_id", mem_readdataid, 0);
        chk("rst_rdata", mem_readdata, 0);
        rst = 1'b0;
        @(negedge clock);
        chk("idle_wait", mem_waitrequest, 0);

        issue(0, 1, 30'h10, 2'd0, 32'hDEADBEEF, 4'hF, 0, 0);
        issue(1, 0, 30'h10, 2'd2, 32'h0, 4'h0, 0, 1);
        chk("rd_lo_a", ram_a, 22'h20);
        chk("rd_lo_strobe", {ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n}, 5'b00100);
        repeat (4) @(negedge clock);
        chk("rd_hi_a", ram_a, 22'h21);
        drain();
        chk("rd_hold", mem_readdata, 32'hDEADBEEF);

        issue(0, 1, 30'h20, 2'd0, 32'h11223344, 4'hF, 0, 0);
        issue(0, 1, 30'h20, 2'd0, 32'h00AA0000, 4'h4, 0, 0);
        repeat (12) @(negedge clock);
        chk("mask4_ce_len", last_ce_run, MASK4_CE);
        issue(1, 0, 30'h20, 2'd1, 32'h0, 4'h0, 0, 1);
        drain();
        chk("mask4_rdata", mem_readdata, 32'h11AA3344);

        issue(1, 0, 30'h10, 2'd1, 32'h0, 4'h0, 1, 1);
        a1 = last_acc;
        issue(1, 0, 30'h20, 2'd2, 32'h0, 4'h0, 1, 1);
        a2 = last_acc;
        issue(1, 0, 30'h3, 2'd3, 32'h0, 4'h0, 0, 1);
        a3 = last_acc;
        chk("b2b_gap12", a2 - a1, 2 * RC + 2);
        chk("b2b_gap23", a3 - a2, 2 * RC + 2);
        drain();

        issue(1, 0, 30'h10, 2'd3, 32'h0, 4'h0, 0, 0);
        repeat (5) @(negedge clock);
        rst = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_strobes", {ram_ce_n, ram_oe_n, ram_we_n}, 3'b111);
        chk("abort_id", mem_readdataid, 0);
        chk("abort_wait", mem_waitrequest, 1);
        @(negedge clock);
        rst = 1'b0;
        repeat (12) @(negedge clock);
        issue(1, 0, 30'h20, 2'd2, 32'h0, 4'h0, 0, 1);
        drain();

        issue(1, 1, 30'h3, 2'd1, 32'hCAFEF00D, 4'hF, 0, 1);
        repeat (12) @(negedge clock);
        issue(1, 0, 30'h3, 2'd1, 32'h0, 4'h0, 0, 1);
        drain();

        issue(0, 1, 30'h3FFFFFFF, 2'd0, $urandom, 4'hF, 0, 0);
        issue(1, 0, 30'h3FFFFFFF, 2'd2, 32'h0, 4'h0, 0, 1);
        repeat (4) @(negedge clock);
        chk("wrap_hi_a", ram_a, 22'h3FFFFF);
        drain();
        issue(1, 0, 30'h001FFFFF, 2'd3, 32'h0, 4'h0, 0, 1);
        issue(0, 1, 30'h20000005, 2'd0, 32'h5555AAAA, 4'hF, 0, 0);
        issue(1, 0, 30'h5, 2'd1, 32'h0, 4'h0, 0, 1);
        drain();

        for (int i = 0; i < 24; i++) begin
            logic [29:0] a;
            a = {9'($urandom), pool[$urandom_range(0, 7)]};
            if ($urandom_range(0, 1) == 1)
                issue(0, 1, a, 2'd0, $urandom, 4'($urandom_range(0, 15)), 0, 0);
            else
                issue(1, 0, a, 2'($urandom_range(1, 3)), 32'h0, 4'h0, 0, 1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
